pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the five-stage MIPS core. It generalises the fixed E→M register into one block that can be instantiated between any two stages. It carries a generic payload plus PC, opcode, Tnew, exception code and branch-delay flag. It adds a valid/ready stall handshake, a distinct bubble-flush that preserves PC/bd for EPC, interrupt flush to the handler vector, and an optional skid entry.

---
 rtl/pipe_stage_reg.sv | 178 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with stall, flush, interrupt and optional skid.
// Define PIPE_SKID_EN to add one skid entry and a registered in_ready.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W = 8,
  parameter int unsigned TNEW_W = 3,
  parameter logic [OP_W-1:0] NOP_OP = OP_W'(43),
  parameter logic [4:0] NONE_EXC = 5'd31,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] INT_PC = 32'h0000_4180
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              int_req,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_regwrite,
  input  logic              in_memwrite,
  input  logic [TNEW_W-1:0] in_tnew,
  input  logic [4:0]        in_exc,
  input  logic              in_bd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [OP_W-1:0]   out_op,
  output logic [DATA_W-1:0] out_data,
  output logic              out_regwrite,
  output logic              out_memwrite,
  output logic [TNEW_W-1:0] out_tnew,
  output logic [4:0]        out_exc,
  output logic              out_bd
);

  typedef struct packed {
    logic [31:0]       pc;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] data;
    logic              regwrite;
    logic              memwrite;
    logic [TNEW_W-1:0] tnew;
    logic [4:0]        exc;
    logic              bd;
  } ent_t;

  ent_t main_q, main_d;
  ent_t in_ent, bub_ent, rst_ent, int_ent;
  logic valid_q, valid_d;
  logic advance;

  always_comb begin
    in_ent.pc = in_pc;
    in_ent.op = in_op;
    in_ent.data = in_data;
    in_ent.regwrite = in_regwrite;
    in_ent.memwrite = in_memwrite;
    in_ent.tnew = (in_tnew == '0) ? '0
                : in_tnew - TNEW_W'(1);
    in_ent.exc = in_exc;
    in_ent.bd = in_bd;
  end

  // Bubbles keep pc/bd so a later exception reports a correct EPC
  always_comb begin
    bub_ent.pc = in_pc;
    bub_ent.op = NOP_OP;
    bub_ent.data = '0;
    bub_ent.regwrite = 1'b0;
    bub_ent.memwrite = 1'b0;
    bub_ent.tnew = '0;
    bub_ent.exc = NONE_EXC;
    bub_ent.bd = in_bd;
  end

  always_comb begin
    rst_ent = bub_ent;
    rst_ent.pc = RESET_PC;
    rst_ent.bd = 1'b0;
    int_ent = rst_ent;
    int_ent.pc = INT_PC;
  end

  assign advance = out_ready | ~valid_q;

`ifdef PIPE_SKID_EN
  ent_t skid_q, skid_d;
  logic skid_v_q, skid_v_d;

  assign in_ready = ~skid_v_q;

  always_comb begin
    main_d = main_q;
    valid_d = valid_q;
    skid_d = skid_q;
    skid_v_d = skid_v_q;
    if (int_req) begin
      main_d = int_ent;
      valid_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (flush) begin
      main_d = bub_ent;
      valid_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (advance) begin
      if (skid_v_q) begin
        main_d = skid_q;
        valid_d = 1'b1;
        skid_v_d = 1'b0;
      end else if (in_valid) begin
        main_d = in_ent;
        valid_d = 1'b1;
      end else begin
        main_d = bub_ent;
        valid_d = 1'b0;
      end
    end else if (in_valid && !skid_v_q) begin
      skid_d = in_ent;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_q <= rst_ent;
      skid_v_q <= 1'b0;
    end else begin
      skid_q <= skid_d;
      skid_v_q <= skid_v_d;
    end
  end
`else
  assign in_ready = advance;

  always_comb begin
    main_d = main_q;
    valid_d = valid_q;
    if (int_req) begin
      main_d = int_ent;
      valid_d = 1'b0;
    end else if (flush) begin
      main_d = bub_ent;
      valid_d = 1'b0;
    end else if (advance) begin
      if (in_valid) begin
        main_d = in_ent;
        valid_d = 1'b1;
      end else begin
        main_d = bub_ent;
        valid_d = 1'b0;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= rst_ent;
      valid_q <= 1'b0;
    end else begin
      main_q <= main_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_pc = main_q.pc;
  assign out_op = main_q.op;
  assign out_data = main_q.data;
  assign out_regwrite = main_q.regwrite;
  assign out_memwrite = main_q.memwrite;
  assign out_tnew = main_q.tnew;
  assign out_exc = main_q.exc;
  assign out_bd = main_q.bd;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: vector table, hand sequences, random model.
// Skid sequence is built when PIPE_SKID_EN is defined.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic reset, int_req, flush, in_valid, out_ready;
  logic in_ready, out_valid;
  logic [31:0] in_pc, out_pc;
  logic [7:0] in_op, out_op;
  logic [31:0] in_data, out_data;
  logic in_regwrite, in_memwrite, out_regwrite, out_memwrite;
  logic [2:0] in_tnew, out_tnew;
  logic [4:0] in_exc, out_exc;
  logic in_bd, out_bd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .int_req(int_req), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_op(in_op), .in_data(in_data),
    .in_regwrite(in_regwrite), .in_memwrite(in_memwrite),
    .in_tnew(in_tnew), .in_exc(in_exc), .in_bd(in_bd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_op(out_op), .out_data(out_data),
    .out_regwrite(out_regwrite), .out_memwrite(out_memwrite),
    .out_tnew(out_tnew), .out_exc(out_exc), .out_bd(out_bd)
  );

  typedef struct {
    logic ir, fl, iv, ordy;
    logic [31:0] pc;
    logic [7:0] op;
    logic [2:0] tn;
    logic rw;
    logic [4:0] exc;
    logic bd;
    logic e_rdy, e_v;
    logic [31:0] e_pc;
    logic [7:0] e_op;
    logic [2:0] e_tn;
    logic e_rw;
    logic [4:0] e_exc;
    logic e_bd;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic ir, fl, iv, ordy,
                        input logic [31:0] pc, input logic [7:0] op,
                        input logic [2:0] tn, input logic rw,
                        input logic [4:0] exc, input logic bd);
    int_req = ir; flush = fl; in_valid = iv; out_ready = ordy;
    in_pc = pc; in_op = op; in_tnew = tn; in_regwrite = rw;
    in_exc = exc; in_bd = bd;
    in_data = pc ^ 32'hA5A5_A5A5;
    in_memwrite = op[0];
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference state, updated from the behavioural rules each cycle
  logic m_v, m_rw, m_mw, m_bd;
  logic [31:0] m_pc, m_data;
  logic [7:0] m_op;
  int m_tn;
  logic [4:0] m_exc;

  task automatic model_clear(input logic [31:0] pc, input logic bd);
    m_v = 0; m_pc = pc; m_op = 8'd43; m_data = 0;
    m_rw = 0; m_mw = 0; m_tn = 0; m_exc = 5'd31; m_bd = bd;
  endtask

  initial begin
    reset = 1'b0;
    set_in(0, 0, 0, 0, 32'h0, 8'h0, 3'd0, 0, 5'd0, 0);
    #12;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_pc", 64'(out_pc), 64'h3000);
    check("rst_op", 64'(out_op), 64'd43);
    check("rst_exc", 64'(out_exc), 64'd31);
    check("rst_tnew", 64'(out_tnew), 64'd0);
    reset = 1'b1;

`ifndef PIPE_SKID_EN
    vecs[0] = '{0,0,1,1,32'h3004,8'd5,3'd2,1,5'd31,0,
                1,1,32'h3004,8'd5,3'd1,1,5'd31,0};
    vecs[1] = '{0,0,1,1,32'h3008,8'd6,3'd0,1,5'd31,0,
                1,1,32'h3008,8'd6,3'd0,1,5'd31,0};
    vecs[2] = '{0,0,1,0,32'h300c,8'd7,3'd3,0,5'd2,0,
                0,1,32'h3008,8'd6,3'd0,1,5'd31,0};
    vecs[3] = vecs[2];
    vecs[4] = vecs[2];
    vecs[5] = '{0,1,1,0,32'h3020,8'd9,3'd3,1,5'd4,1,
                0,0,32'h3020,8'd43,3'd0,0,5'd31,1};
    vecs[6] = '{0,0,1,0,32'h3024,8'd10,3'd3,0,5'd12,1,
                1,1,32'h3024,8'd10,3'd2,0,5'd12,1};
    vecs[7] = '{1,1,1,1,32'h3028,8'd11,3'd3,1,5'd5,1,
                1,0,32'h4180,8'd43,3'd0,0,5'd31,0};
    vecs[8] = '{0,0,0,0,32'h3030,8'd12,3'd3,1,5'd5,1,
                1,0,32'h3030,8'd43,3'd0,0,5'd31,1};
    vecs[9] = '{0,0,1,1,32'h3034,8'd1,3'd1,1,5'd31,0,
                1,1,32'h3034,8'd1,3'd0,1,5'd31,0};
    vecs[10] = '{0,0,1,1,32'h3010,8'd2,3'd7,1,5'd31,0,
                 1,1,32'h3010,8'd2,3'd6,1,5'd31,0};
    for (int i = 0; i < 11; i++) begin
      set_in(vecs[i].ir, vecs[i].fl, vecs[i].iv, vecs[i].ordy,
             vecs[i].pc, vecs[i].op, vecs[i].tn, vecs[i].rw,
             vecs[i].exc, vecs[i].bd);
      #1;
      check($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_rdy));
      tick();
      check($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vecs[i].e_v));
      check($sformatf("v%0d_pc", i), 64'(out_pc), 64'(vecs[i].e_pc));
      check($sformatf("v%0d_op", i), 64'(out_op), 64'(vecs[i].e_op));
      check($sformatf("v%0d_tnew", i), 64'(out_tnew), 64'(vecs[i].e_tn));
      check($sformatf("v%0d_rw", i), 64'(out_regwrite), 64'(vecs[i].e_rw));
      check($sformatf("v%0d_exc", i), 64'(out_exc), 64'(vecs[i].e_exc));
      check($sformatf("v%0d_bd", i), 64'(out_bd), 64'(vecs[i].e_bd));
    end
`else
    // Stall downstream while offering A then B
    set_in(0, 0, 1, 0, 32'h3100, 8'd3, 3'd2, 1, 5'd31, 0);
    tick();
    check("sk_a_pc", 64'(out_pc), 64'h3100);
    check("sk_a_rdy", 64'(in_ready), 64'd1);
    set_in(0, 0, 1, 0, 32'h3104, 8'd4, 3'd3, 1, 5'd31, 1);
    tick();
    check("sk_hold_pc", 64'(out_pc), 64'h3100);
    check("sk_hold_tn", 64'(out_tnew), 64'd1);
    check("sk_full_rdy", 64'(in_ready), 64'd0);
    set_in(0, 0, 1, 1, 32'h3108, 8'd5, 3'd5, 1, 5'd31, 0);
    tick();
    check("sk_b_pc", 64'(out_pc), 64'h3104);
    check("sk_b_tn", 64'(out_tnew), 64'd2);
    check("sk_b_v", 64'(out_valid), 64'd1);
    check("sk_empty_rdy", 64'(in_ready), 64'd1);
    set_in(0, 0, 0, 1, 32'h310c, 8'd5, 3'd0, 0, 5'd31, 0);
    tick();
    // Refill both entries, then interrupt during the stall
    set_in(0, 0, 1, 0, 32'h3200, 8'd6, 3'd1, 1, 5'd31, 0);
    tick();
    set_in(0, 0, 1, 0, 32'h3204, 8'd7, 3'd1, 1, 5'd31, 0);
    tick();
    check("sk2_full_rdy", 64'(in_ready), 64'd0);
    set_in(1, 0, 0, 0, 32'h3208, 8'd7, 3'd1, 1, 5'd31, 0);
    tick();
    check("sk_int_pc", 64'(out_pc), 64'h4180);
    check("sk_int_v", 64'(out_valid), 64'd0);
    check("sk_int_rdy", 64'(in_ready), 64'd1);
    set_in(0, 0, 0, 1, 32'h320c, 8'd7, 3'd1, 1, 5'd31, 0);
    tick();
    check("sk_drop_v", 64'(out_valid), 64'd0);
    set_in(0, 0, 1, 1, 32'h3010, 8'd2, 3'd7, 1, 5'd31, 0);
    tick();
    check("sk_ld_pc", 64'(out_pc), 64'h3010);
`endif

    // Asynchronous reset with a live instruction held
    check("pre_rst_v", 64'(out_valid), 64'd1);
    reset = 1'b0;
    #1;
    check("async_pc", 64'(out_pc), 64'h3000);
    check("async_op", 64'(out_op), 64'd43);
    check("async_exc", 64'(out_exc), 64'd31);
    check("async_valid", 64'(out_valid), 64'd0);
    #1;
    reset = 1'b1;

`ifndef PIPE_SKID_EN
    model_clear(32'h3000, 1'b0);
    for (int c = 0; c < 400; c++) begin
      logic ir, fl, iv, ordy, e_rdy;
      ir = ($urandom_range(0, 19) == 0);
      fl = ($urandom_range(0, 11) == 0);
      iv = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      set_in(ir, fl, iv, ordy, $urandom, 8'($urandom),
             3'($urandom), 1'($urandom), 5'($urandom), 1'($urandom));
      e_rdy = ordy || !m_v;
      #1;
      check("rnd_in_ready", 64'(in_ready), 64'(e_rdy));
      tick();
      if (ir) model_clear(32'h4180, 1'b0);
      else if (fl || (e_rdy && !iv)) model_clear(in_pc, in_bd);
      else if (e_rdy) begin
        m_v = 1; m_pc = in_pc; m_op = in_op; m_data = in_data;
        m_rw = in_regwrite; m_mw = in_memwrite; m_exc = in_exc;
        m_bd = in_bd;
        m_tn = (int'(in_tnew) > 0) ? int'(in_tnew) - 1 : 0;
      end
      check("rnd_valid", 64'(out_valid), 64'(m_v));
      check("rnd_pc", 64'(out_pc), 64'(m_pc));
      check("rnd_op", 64'(out_op), 64'(m_op));
      check("rnd_data", 64'(out_data), 64'(m_data));
      check("rnd_rw", 64'(out_regwrite), 64'(m_rw));
      check("rnd_mw", 64'(out_memwrite), 64'(m_mw));
      check("rnd_tnew", 64'(out_tnew), 64'(m_tn));
      check("rnd_exc", 64'(out_exc), 64'(m_exc));
      check("rnd_bd", 64'(out_bd), 64'(m_bd));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
